// File: rtl/bcd_seg_formatter_pkg.sv
// Shared definitions for the BCD-to-7-segment formatter: segment bytes, FSM states and
// conversion limits.
package bcd_seg_formatter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ENC  = 2'd2
    } state_t;

    // Segment bytes are {dp,g,f,e,d,c,b,a}, active-low.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [3:0]  ITER_LAST = 4'd13;
    localparam logic [13:0] MAX_VAL   = 14'd9999;

    function automatic logic [3:0] add3(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/bcd_seg_formatter_seg7.sv
// Combinational BCD digit to active-low 7-segment byte; codes 10..15 never occur and
// are shown blank.
module seg7_encode
    import bcd_seg_formatter_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_seg_formatter.sv
// Accepts a 14-bit value over valid/ready, converts it to BCD by sequential double-dabble
// and publishes four active-low segment bytes for the scanning display controller.
module bcd_seg_formatter
    import bcd_seg_formatter_pkg::*;
#(
    parameter bit         BLANK_LZ = 1'b1,
    parameter logic [3:0] DP_MASK  = 4'b0000
)
(
    input  logic        clk_s,
    input  logic        rst_s,
    input  logic [13:0] bin_s,
    input  logic        valid_s,
    output logic        ready_s,
    output logic [31:0] sseg_s,
    output logic        done_s
);

    state_t      state_q;
    logic        ready_q;
    logic        done_q;
    logic        overflow_q;
    logic [3:0]  iterCnt_q;
    logic [15:0] bcd_q;
    logic [13:0] binShift_q;
    logic [31:0] sseg_q;

    logic [15:0] bcdAdj;
    logic [29:0] shifted;
    logic [7:0]  segRaw [4];
    logic [3:0]  blankDigit;
    logic [31:0] sseg_d;
    logic [7:0]  digitByte;

    // One double-dabble step: correct every nibble, then shift the whole register left.
    assign bcdAdj  = {add3(bcd_q[15:12]), add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    assign shifted = {bcdAdj, binShift_q} << 1;

    genvar g;
    for (g = 0; g < 4; g++) begin : gEnc
        seg7_encode uEnc (
            .bcd_i (bcd_q[4*g +: 4]),
            .seg_o (segRaw[g])
        );
    end

    // A digit is blank only when it and every digit to its left are zero.
    assign blankDigit[3] = BLANK_LZ && (bcd_q[15:12] == 4'd0);
    assign blankDigit[2] = blankDigit[3] && (bcd_q[11:8] == 4'd0);
    assign blankDigit[1] = blankDigit[2] && (bcd_q[7:4] == 4'd0);
    assign blankDigit[0] = 1'b0;

    always_comb begin
        sseg_d    = '1;
        digitByte = SEG_BLANK;
        for (int i = 0; i < 4; i++) begin
            if (overflow_q) begin
                digitByte = SEG_DASH;
            end else if (blankDigit[i]) begin
                digitByte = SEG_BLANK;
            end else begin
                digitByte = segRaw[i];
            end
            if (DP_MASK[i]) begin
                digitByte[7] = 1'b0;
            end
            sseg_d[8*i +: 8] = digitByte;
        end
    end

    // The output pattern only changes on the ENC edge, so the display never sees partial results.
    always_ff @(posedge clk_s or negedge rst_s) begin
        if (!rst_s) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            iterCnt_q  <= '0;
            bcd_q      <= '0;
            binShift_q <= '0;
            sseg_q     <= '1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_s && ready_q) begin
                        state_q    <= CONV;
                        ready_q    <= 1'b0;
                        binShift_q <= bin_s;
                        bcd_q      <= '0;
                        iterCnt_q  <= '0;
                        overflow_q <= (bin_s > MAX_VAL);
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                CONV: begin
                    bcd_q      <= shifted[29:14];
                    binShift_q <= shifted[13:0];
                    iterCnt_q  <= iterCnt_q + 4'd1;
                    if (iterCnt_q == ITER_LAST) begin
                        state_q <= ENC;
                    end
                end
                ENC: begin
                    sseg_q  <= sseg_d;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_s = ready_q;
    assign done_s  = done_q;
    assign sseg_s  = sseg_q;

endmodule

// File: tb/tb_bcd_seg_formatter.sv
// Scoreboard bench for bcd_seg_formatter: three instances (default, no blanking, dp on
// digit 2) share stimulus; expected bytes come from an arithmetic decimal model.
module tb_bcd_seg_formatter;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } expT;

   logic        clkS;
   logic        rstS;
   logic [13:0] binS;
   logic        validS;
   logic        readyA, readyB, readyC;
   logic        doneA, doneB, doneC;
   logic [31:0] ssegA, ssegB, ssegC;

   int          checkCount;
   int          errorCount;
   expT         expQ[$];
   expT         popped;
   logic [31:0] prevSsegA;
   logic        prevDoneA;
   logic        prevRst;
   logic [7:0]  segTab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   bcd_seg_formatter #(.BLANK_LZ(1'b1), .DP_MASK(4'b0000)) dutA (
      .clk_s(clkS), .rst_s(rstS), .bin_s(binS), .valid_s(validS),
      .ready_s(readyA), .sseg_s(ssegA), .done_s(doneA));

   bcd_seg_formatter #(.BLANK_LZ(1'b0), .DP_MASK(4'b0000)) dutB (
      .clk_s(clkS), .rst_s(rstS), .bin_s(binS), .valid_s(validS),
      .ready_s(readyB), .sseg_s(ssegB), .done_s(doneB));

   bcd_seg_formatter #(.BLANK_LZ(1'b1), .DP_MASK(4'b0100)) dutC (
      .clk_s(clkS), .rst_s(rstS), .bin_s(binS), .valid_s(validS),
      .ready_s(readyC), .sseg_s(ssegC), .done_s(doneC));

   initial clkS = 1'b0;
   always #5 clkS = ~clkS;

   // Counts one comparison and reports it when the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Decimal model: digit i is blank when the value is below 10^i (never digit 0).
   function automatic logic [31:0] expSeg(input int v, input bit blankLz, input logic [3:0] dp);
      logic [31:0] r;
      logic [7:0]  b;
      int          pw;
      r  = '1;
      pw = 1;
      for (int i = 0; i < 4; i++) begin
         if (v > 9999) b = 8'hBF;
         else if (blankLz && i > 0 && v < pw) b = 8'hFF;
         else b = segTab[(v / pw) % 10];
         if (dp[i]) b[7] = 1'b0;
         r[8*i +: 8] = b;
         pw = pw * 10;
      end
      return r;
   endfunction

   // Drives one transfer, scrambles bin_s during conversion and times the done pulse.
   task automatic applyStimulus(input logic [13:0] value, input bit holdValid);
      int  waitCycles;
      int  edges;
      expT e;
      waitCycles = 0;
      while (!readyA && waitCycles < 40) begin
         @(negedge clkS);
         waitCycles++;
      end
      checkOutput("readyWait", {31'd0, readyA}, 32'd1);
      binS   = value;
      validS = 1'b1;
      @(posedge clkS);
      e.a = expSeg(int'(value), 1'b1, 4'b0000);
      e.b = expSeg(int'(value), 1'b0, 4'b0000);
      e.c = expSeg(int'(value), 1'b1, 4'b0100);
      expQ.push_back(e);
      #1;
      binS   = value ^ 14'h15A5;
      validS = holdValid;
      edges  = 0;
      do begin
         @(negedge clkS);
         edges++;
         if (!doneA) checkOutput("readyLowConv", {31'd0, readyA}, 32'd0);
      end while (!doneA && edges < 40);
      checkOutput("doneSeen", {31'd0, doneA}, 32'd1);
      checkOutput("latency", edges - 1, 32'd15);
      checkOutput("readyBack", {31'd0, readyA}, 32'd1);
   endtask

   // Scoreboard and continuous properties, sampled mid-cycle.
   always @(negedge clkS) begin
      if (rstS) begin
         checkOutput("doneB", {31'd0, doneB}, {31'd0, doneA});
         checkOutput("doneC", {31'd0, doneC}, {31'd0, doneA});
         checkOutput("readyB", {31'd0, readyB}, {31'd0, readyA});
         if (doneA) begin
            checkOutput("donePulse", {31'd0, prevDoneA}, 32'd0);
            if (expQ.size() == 0) begin
               checkOutput("spuriousDone", 32'd1, 32'd0);
            end else begin
               popped = expQ.pop_front();
               checkOutput("ssegA", ssegA, popped.a);
               checkOutput("ssegB", ssegB, popped.b);
               checkOutput("ssegC", ssegC, popped.c);
            end
         end else if (prevRst) begin
            checkOutput("ssegHold", ssegA, prevSsegA);
         end
      end
      prevSsegA = ssegA;
      prevDoneA = doneA;
      prevRst   = rstS;
   end

   initial begin
      checkCount = 0;
      errorCount = 0;
      prevSsegA  = '1;
      prevDoneA  = 1'b0;
      prevRst    = 1'b0;
      rstS       = 1'b0;
      validS     = 1'b0;
      binS       = '0;

      #12;
      checkOutput("rstSseg", ssegA, 32'hFFFF_FFFF);
      checkOutput("rstReady", {31'd0, readyA}, 32'd0);
      checkOutput("rstDone", {31'd0, doneA}, 32'd0);
      @(negedge clkS);
      rstS = 1'b1;
      #1;
      checkOutput("readyBeforeEdge", {31'd0, readyA}, 32'd0);
      @(negedge clkS);
      checkOutput("readyAfterRelease", {31'd0, readyA}, 32'd1);

      applyStimulus(14'd1234, 1'b0);
      applyStimulus(14'd7, 1'b0);
      applyStimulus(14'd0, 1'b0);
      applyStimulus(14'd9999, 1'b0);
      applyStimulus(14'd10000, 1'b0);
      applyStimulus(14'd16383, 1'b0);
      applyStimulus(14'd5, 1'b1);
      applyStimulus(14'd42, 1'b0);
      applyStimulus(14'd3141, 1'b0);
      applyStimulus(14'd10, 1'b0);
      applyStimulus(14'd100, 1'b0);

      // Abort a conversion with reset; no done pulse may follow.
      @(negedge clkS);
      binS   = 14'd8765;
      validS = 1'b1;
      @(posedge clkS);
      #1;
      validS = 1'b0;
      repeat (6) @(negedge clkS);
      #2;
      rstS = 1'b0;
      #1;
      checkOutput("midRstSseg", ssegA, 32'hFFFF_FFFF);
      checkOutput("midRstReady", {31'd0, readyA}, 32'd0);
      checkOutput("midRstDone", {31'd0, doneA}, 32'd0);
      repeat (2) @(negedge clkS);
      #2;
      rstS = 1'b1;
      repeat (20) @(negedge clkS);
      checkOutput("noDoneAfterAbort", expQ.size(), 32'd0);

      for (int k = 0; k < 6; k++) begin
         applyStimulus(14'($urandom_range(0, 16383)), 1'b0);
      end

      repeat (3) @(negedge clkS);
      checkOutput("queueEmpty", expQ.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
